fm_cmn_bfifo_00: RTL and testbench

Synchronous first-word-fall-through FIFO controller. It instantiates fm_cmn_bram_00 as storage: it drives the write port (we/a/di) and the read address (dpra), and consumes dpo. The block absorbs the one-cycle registered-address read latency of the RAM with a 2-entry output buffer, so it sustains one pop per clock. It sits between producer/consumer stages of the pipeline using the team's strobe/ack handshake.

---
 rtl/fm_cmn_pkg.sv | 21 ++
 rtl/fm_cmn_bram_00.sv | 30 +++
 rtl/fm_cmn_bfifo_00.sv | 139 +++++++++++++
 tb/tb_fm_cmn_bfifo_00.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fm_cmn_pkg.sv
// Shared definitions for the fm_cmn FIFO blocks: output-buffer depth, occupancy
// encoding of the head/skid pair, and a constant-foldable log2 helper.
package fm_cmn_pkg;

   localparam int BUF_DEPTH = 2;

   localparam logic [1:0] OUT_EMPTY = 2'd0;
   localparam logic [1:0] OUT_ONE   = 2'd1;
   localparam logic [1:0] OUT_TWO   = 2'd2;

   // Bits needed to hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/fm_cmn_bram_00.sv
// Simple dual-port RAM: synchronous write port, read port with a registered
// address so dpo follows dpra by one cycle and reflects a write at the same edge.
module fm_cmn_bram_00 #(
   parameter int P_WIDTH = 32,
   parameter int P_RANGE = 4,
   parameter int P_DEPTH = 1 << P_RANGE
) (
   input  logic               clk,
   input  logic               we,
   input  logic [P_RANGE-1:0] a,
   input  logic [P_WIDTH-1:0] di,
   input  logic [P_RANGE-1:0] dpra,
   output logic [P_WIDTH-1:0] dpo
);

   logic [P_WIDTH-1:0] mem_q [P_DEPTH];
   logic [P_RANGE-1:0] dpra_q;

   // NOTE: the array and its read address carry no reset so the storage maps onto
   // block RAM; the controller never presents data it has not fetched.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[a] <= di;
      end
      dpra_q <= dpra;
   end

   assign dpo = mem_q[dpra_q];

endmodule

// File: rtl/fm_cmn_bfifo_00.sv
// First-word-fall-through FIFO over fm_cmn_bram_00 with a 2-entry head/skid buffer
// hiding the RAM read latency. Optional sticky protocol check: FM_CMN_BFIFO_ERR_CHK_EN.
module fm_cmn_bfifo_00
   import fm_cmn_pkg::*;
#(
   parameter int P_WIDTH = 32,
   parameter int P_RANGE = 4,
   parameter int P_DEPTH = 1 << P_RANGE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wstr,
   input  logic [P_WIDTH-1:0] i_wdata,
   output logic               o_wack,
   output logic               o_rstr,
   output logic [P_WIDTH-1:0] o_rdata,
   input  logic               i_rack,
   output logic [P_RANGE+1:0] o_cnt,
   output logic               o_err
);

   localparam int CNT_W = clog2(P_DEPTH + 3);

   logic [P_RANGE-1:0] wr_ptr_q, wr_ptr_d;
   logic [P_RANGE-1:0] rd_ptr_q, rd_ptr_d;
   logic [P_RANGE:0]   ram_cnt_q, ram_cnt_d;
   logic [1:0]         out_cnt_q, out_cnt_d;
   logic               inflight_q, inflight_d;
   logic [P_WIDTH-1:0] head_q, head_d;
   logic [P_WIDTH-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               ram_full;
   logic               push;
   logic               pop;
   logic               fetch;
   logic [2:0]         occ_after_pop;
   logic [1:0]         avail;
   logic [P_WIDTH-1:0] dpo;

   fm_cmn_bram_00 #(
      .P_WIDTH (P_WIDTH),
      .P_RANGE (P_RANGE),
      .P_DEPTH (P_DEPTH)
   ) u_bram (
      .clk  (clk),
      .we   (push),
      .a    (wr_ptr_q),
      .di   (i_wdata),
      .dpra (rd_ptr_q),
      .dpo  (dpo)
   );

   assign ram_full = (ram_cnt_q == (P_RANGE+1)'(P_DEPTH));
   assign o_wack   = ~ram_full;
   assign o_rstr   = (out_cnt_q != OUT_EMPTY);
   assign push     = i_wstr & o_wack;
   assign pop      = o_rstr & i_rack;

   // Buffer occupancy once this cycle's pop leaves and any in-flight word lands;
   // a new fetch is only issued if its data is guaranteed a slot next cycle.
   assign occ_after_pop = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fetch         = (ram_cnt_q != '0) && (occ_after_pop < 3'(BUF_DEPTH));
   assign avail         = out_cnt_q - {1'b0, pop};

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q + P_RANGE'(push);
      rd_ptr_d   = rd_ptr_q + P_RANGE'(fetch);
      ram_cnt_d  = ram_cnt_q + (P_RANGE+1)'(push) - (P_RANGE+1)'(fetch);
      cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
      inflight_d = fetch;
      out_cnt_d  = occ_after_pop[1:0];
      head_d     = head_q;
      skid_d     = skid_q;

      if (pop && (out_cnt_q == OUT_TWO)) begin
         head_d = skid_q;
      end
      // Arriving RAM data fills the head when it is free after the pop, else the skid.
      if (inflight_q) begin
         if (avail == OUT_EMPTY) begin
            head_d = dpo;
         end else begin
            skid_d = dpo;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         out_cnt_q  <= OUT_EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
         cnt_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         out_cnt_q  <= out_cnt_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_rdata = head_q;
   assign o_cnt   = (P_RANGE+2)'(cnt_q);

`ifdef FM_CMN_BFIFO_ERR_CHK_EN
   logic err_q, err_d;

   // Overflow attempt (strobe while full) or underflow attempt (ack while empty).
   always_comb begin
      err_d = err_q | (i_wstr & ~o_wack) | (i_rack & ~o_rstr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fm_cmn_bfifo_00.sv
// Self-checking bench for fm_cmn_bfifo_00: queue-based occupancy model compared every
// cycle, plus literal expectations for latency, fill limit, reset and the error flag.
module tb_fm_cmn_bfifo_00;

   localparam int W = 32;
   localparam int R = 4;
   localparam int D = 1 << R;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_wstr;
   logic [W-1:0] i_wdata;
   logic         o_wack;
   logic         o_rstr;
   logic [W-1:0] o_rdata;
   logic         i_rack;
   logic [R+1:0] o_cnt;
   logic         o_err;

   fm_cmn_bfifo_00 #(.P_WIDTH(W), .P_RANGE(R)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_wstr  (i_wstr),
      .i_wdata (i_wdata),
      .o_wack  (o_wack),
      .o_rstr  (o_rstr),
      .o_rdata (o_rdata),
      .i_rack  (i_rack),
      .o_cnt   (o_cnt),
      .o_err   (o_err)
   );

   always #5 clk = ~clk;

   // Model: mq holds every word in order; the first m_b are in the output buffer,
   // the next m_f are being fetched, the rest sit in RAM (m_r of them).
   logic [W-1:0] mq[$];
   int           m_r, m_f, m_b;
   bit           m_err;
   bit           model_ok;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      check("o_rstr", 64'(o_rstr), 64'(m_b > 0));
      check("o_wack", 64'(o_wack), 64'(m_r != D));
      check("o_cnt", 64'(o_cnt), 64'(mq.size()));
      if (m_b > 0) check("o_rdata", 64'(o_rdata), 64'(mq[0]));
      check("o_err", 64'(o_err), 64'(m_err));
   endtask

   // One clock: drive inputs, compare on the falling edge, advance the model after the rising edge.
   task automatic cycle(input bit wstr, input logic [W-1:0] wd, input bit rack, input bit r);
      bit push, pop, fetch;
      rst     = r;
      i_wstr  = wstr;
      i_wdata = wd;
      i_rack  = rack;
      @(negedge clk);
      if (model_ok) compare_outputs();
      push  = wstr && (m_r != D);
      pop   = rack && (m_b > 0);
      fetch = (m_r > 0) && (m_b + m_f - int'(pop) < 2);
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         m_r = 0; m_f = 0; m_b = 0; m_err = 1'b0;
         model_ok = 1'b1;
      end else begin
`ifdef FM_CMN_BFIFO_ERR_CHK_EN
         if ((wstr && m_r == D) || (rack && m_b == 0)) m_err = 1'b1;
`endif
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(wd);
         m_b = m_b - int'(pop) + m_f;
         m_f = int'(fetch);
         m_r = m_r + int'(push) - int'(fetch);
      end
   endtask

   initial begin
      int drained;
      bit exp_err;
      model_ok = 1'b0;
      rst = 1'b1; i_wstr = 1'b0; i_wdata = '0; i_rack = 1'b0;
`ifdef FM_CMN_BFIFO_ERR_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif

      // Reset state and single-word latency.
      cycle(0, '0, 0, 1);
      check("rst_cnt", 64'(o_cnt), 64'd0);
      check("rst_wack", 64'(o_wack), 64'd1);
      check("rst_rstr", 64'(o_rstr), 64'd0);
      check("rst_rdata", 64'(o_rdata), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      cycle(1, 32'hA5A5A5A5, 0, 0);
      check("lat_e0_cnt", 64'(o_cnt), 64'd1);
      check("lat_e0_rstr", 64'(o_rstr), 64'd0);
      cycle(0, '0, 0, 0);
      check("lat_e1_rstr", 64'(o_rstr), 64'd0);
      cycle(0, '0, 0, 0);
      check("lat_e2_rstr", 64'(o_rstr), 64'd1);
      check("lat_e2_rdata", 64'(o_rdata), 64'hA5A5A5A5);
      cycle(0, '0, 1, 0);
      check("pop_cnt", 64'(o_cnt), 64'd0);
      check("pop_rstr", 64'(o_rstr), 64'd0);

      // Fill to capacity with no consumer, then drain in order.
      for (int i = 0; i < D + 2; i++) cycle(1, W'(i), 0, 0);
      check("full_cnt", 64'(o_cnt), 64'(D + 2));
      check("full_wack", 64'(o_wack), 64'd0);
      cycle(1, 32'hDEAD_BEEF, 0, 0);
      check("full_drop_cnt", 64'(o_cnt), 64'(D + 2));
      drained = 0;
      for (int k = 0; k < 40 && drained < D + 2; k++) begin
         if (o_rstr) begin
            check("drain_data", 64'(o_rdata), 64'(drained));
            drained++;
            cycle(0, '0, 1, 0);
         end else begin
            cycle(0, '0, 0, 0);
         end
      end
      check("drain_count", 64'(drained), 64'(D + 2));
      check("drain_empty", 64'(o_cnt), 64'd0);

      // Streaming across pointer wrap: no bubbles, constant occupancy.
      cycle(0, '0, 0, 1);
      for (int i = 0; i < 100; i++) begin
         cycle(1, W'(32'h1000 + i), 1, 0);
         if (i >= 3) begin
            check("stream_rstr", 64'(o_rstr), 64'd1);
            check("stream_cnt", 64'(o_cnt), 64'd3);
         end
      end

      // Reset while a fetch is in flight with 5 words held.
      cycle(0, '0, 0, 1);
      for (int i = 0; i < 5; i++) cycle(1, W'(32'h2000 + i), 0, 0);
      cycle(1, 32'h2005, 1, 0);
      check("mid_cnt", 64'(o_cnt), 64'd5);
      cycle(0, '0, 0, 1);
      check("mid_rst_rstr", 64'(o_rstr), 64'd0);
      check("mid_rst_cnt", 64'(o_cnt), 64'd0);
      check("mid_rst_wack", 64'(o_wack), 64'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(0, '0, 0, 0);
         check("mid_no_stale", 64'(o_rstr), 64'd0);
      end

      // Underflow attempt sets the sticky flag only when checking is built in.
      cycle(0, '0, 1, 0);
      check("err_set", 64'(o_err), 64'(exp_err));
      for (int i = 0; i < 3; i++) cycle(1, W'(i), 0, 0);
      check("err_hold", 64'(o_err), 64'(exp_err));
      cycle(0, '0, 0, 1);
      check("err_clear", 64'(o_err), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 10000; i++) begin
         cycle(bit'($urandom_range(0, 1)), W'($urandom), bit'($urandom_range(0, 1)), 0);
         check("cnt_bound", 64'(o_cnt <= (D + 2)), 64'd1);
      end

      cycle(0, '0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
